pong_engine: RTL and testbench
==============================

# pong_engine

Parametrised game-logic core for the Pong design. It replaces the divided-clock movement controller with a single-clock, tick-enabled engine that owns the paddles, the ball, the scores and a match state machine (idle, serve, play, point, game over). All geometry, speeds, tick rate and winning score are parameters. Outputs feed the VGA renderer and score display.

## Interface
- H_RES, 640, playfield width in pixels
- V_RES, 480, playfield height in pixels
- PADDLE_H, 60, paddle height
- PADDLE_W, 8, paddle width
- PADDLE1_X, 16, left edge of paddle 1
- PADDLE2_X, 616, left edge of paddle 2
- BALL_SIZE, 8, ball side length
- PADDLE_SPEED, 4, paddle pixels per tick
- BALL_DY, 2, vertical ball pixels per tick
- SPEED_INIT, 2, horizontal ball pixels per tick after a serve
- SPEED_MAX, 6, horizontal speed ceiling
- TICK_CYCLES, 416667, clk cycles per game tick (60 Hz at 25 MHz)
- SERVE_TICKS, 60, ticks spent in SERVE before play
- WIN_SCORE, 9, score that ends the match (≤15)
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  level; starts or restarts a match
- p1_up, p1_down, p2_up, p2_down  in  1 each  paddle controls, level
- paddle1_y, paddle2_y  out  10  paddle top edges
- ball_x, ball_y  out  10  ball top-left corner
- ball_direction  out  2  bit0 = 1 moving right, bit1 = 1 moving down
- ball_speed  out  3  current horizontal speed
- p1_score, p2_score  out  4  scores
- game_state  out  3  encoded state
- winner  out  1  0 = player 1, 1 = player 2; valid in OVER
- tick  out  1  one-cycle game-tick pulse

## Operation
- Reset values: paddles (V_RES-PADDLE_H)/2 = 210; ball_x (H_RES-BALL_SIZE)/2 = 316; ball_y (V_RES-BALL_SIZE)/2 = 236; ball_direction 2'b01; ball_speed SPEED_INIT; scores 0; winner 0; state IDLE; tick counter 0.
- Tick counter counts 0..TICK_CYCLES-1. tick is high for the cycle the counter equals TICK_CYCLES-1. All state and position updates occur only on tick cycles.
- States: IDLE, SERVE, PLAY, POINT, OVER.
  - IDLE: everything held. start=1 moves to SERVE.
  - SERVE: paddles move, ball held at centre, serve counter counts SERVE_TICKS ticks, then PLAY.
  - PLAY: paddles and ball move.
  - POINT: scorer's score increments. If the new score equals WIN_SCORE, go to OVER and set winner. Otherwise re-centre the ball, set speed to SPEED_INIT, set bit0 toward the player who conceded, keep bit1, and go to SERVE.
  - OVER: everything frozen. start=1 clears scores and winner, re-centres the ball and goes to SERVE.
- Paddles move in SERVE and PLAY only. up alone: y = max(y-PADDLE_SPEED, 0). down alone: y = min(y+PADDLE_SPEED, V_RES-PADDLE_H). Both or neither: hold.
- Ball in PLAY. Horizontal step is ball_speed; vertical step is BALL_DY.
  - Top wall: moving up with y ≤ BALL_DY → y = 0, bit1 set.
  - Bottom wall: moving down with y+BALL_SIZE+BALL_DY ≥ V_RES → y = V_RES-BALL_SIZE, bit1 cleared.
  - Paddle 1 hit: moving left, x ≥ PADDLE1_X+PADDLE_W, x-speed ≤ PADDLE1_X+PADDLE_W, and the vertical spans overlap (ball_y+BALL_SIZE > paddle1_y and ball_y < paddle1_y+PADDLE_H). Result: x = PADDLE1_X+PADDLE_W, bit0 set, speed = min(speed+1, SPEED_MAX).
  - Paddle 2 hit: mirror of paddle 1, with x clamped to PADDLE2_X-BALL_SIZE.
  - Miss: moving left with x < speed scores for player 2; moving right with x+BALL_SIZE+speed > H_RES scores for player 1. Both go to POINT with the ball held.
  - Wall and paddle events on the same tick both apply independently.
- Overlap tests use pre-move paddle positions for that tick.
- Arithmetic uses 11-bit intermediates, so no 10-bit wrap occurs.

## Timing
- Registered outputs change on the clk edge that ends the tick cycle, i.e. they are visible one cycle after tick is high.
- start is sampled only on tick cycles and must be held for at least TICK_CYCLES cycles.
- Reset asserted mid-game asynchronously forces all reset values. The first tick occurs TICK_CYCLES cycles after reset deasserts.

## Structure
- Package pong_pkg: the state enum, direction bit positions, and default geometry constants.
- Sub-module pong_tick_gen: the parametrised tick counter.
- Paddle update is a function used for both players.

## Test plan
All scenarios use TICK_CYCLES = 4 and SERVE_TICKS = 2.
- Reset, then release: outputs at reset values; tick pulses every 4 cycles; state stays IDLE with start = 0.
- Paddle limits: start, hold p1_down → paddle1_y reaches 420 and stays there. Hold p2_up and p2_down together → paddle2_y stays at 210.
- Top wall: force ball_y = 1 moving up in PLAY → next tick ball_y = 0 and bit1 = 1.
- Paddle 1 hit: ball_x = 25 moving left, speed 2, paddle1_y = 210, ball_y = 236 → ball_x = 24, bit0 = 1, speed 3.
- Miss: ball_x = 1 moving left, paddle 1 away → POINT, p2_score = 1, then SERVE with ball at (316, 236) and bit0 = 0, then PLAY after 2 ticks.
- Match end: p1_score = 8 and paddle 2 misses → p1_score = 9, OVER, winner = 0, ball frozen. Hold start → scores 0, state SERVE.

Source files
------------

// File: rtl/pong_pkg.sv
// Shared definitions for the Pong game engine.
//   state_t      : match state encoding (visible on game_state)
//   DIR_RIGHT/DN : bit positions inside ball_direction
//   DEF_*        : default geometry / timing constants
//   paddle_next  : one tick of paddle motion with clamping
package pong_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SERVE = 3'd1,
    ST_PLAY  = 3'd2,
    ST_POINT = 3'd3,
    ST_OVER  = 3'd4
  } state_t;

  localparam int DIR_RIGHT = 0;
  localparam int DIR_DOWN  = 1;

  localparam int DEF_H_RES        = 640;
  localparam int DEF_V_RES        = 480;
  localparam int DEF_PADDLE_H     = 60;
  localparam int DEF_PADDLE_W     = 8;
  localparam int DEF_PADDLE1_X    = 16;
  localparam int DEF_PADDLE2_X    = 616;
  localparam int DEF_BALL_SIZE    = 8;
  localparam int DEF_PADDLE_SPEED = 4;
  localparam int DEF_BALL_DY      = 2;
  localparam int DEF_SPEED_INIT   = 2;
  localparam int DEF_SPEED_MAX    = 6;
  localparam int DEF_TICK_CYCLES  = 416667;
  localparam int DEF_SERVE_TICKS  = 60;
  localparam int DEF_WIN_SCORE    = 9;

  // up alone moves toward 0, down alone toward y_max, both/neither hold.
  // 11-bit math so y-step and y+step never wrap.
  function automatic logic [9:0] paddle_next(input logic [9:0]  y,
                                             input logic        up,
                                             input logic        dn,
                                             input logic [10:0] step,
                                             input logic [10:0] y_max);
    logic [10:0] y11;
    y11 = {1'b0, y};
    paddle_next = y;
    if (up && !dn)
      paddle_next = (y11 <= step) ? 10'd0 : 10'(y11 - step);
    else if (dn && !up)
      paddle_next = (y11 + step >= y_max) ? 10'(y_max) : 10'(y11 + step);
  endfunction

endpackage

// File: rtl/pong_tick_gen.sv
// Game-tick generator: free-running 0..TICK_CYCLES-1 counter.
//   clk, reset : system clock, async active-high reset
//   tick       : high for the cycle the counter sits at TICK_CYCLES-1
module pong_tick_gen #(
  parameter int TICK_CYCLES = 416667
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);
  localparam int CW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;

  logic [CW-1:0] cnt;

  assign tick = (cnt == CW'(TICK_CYCLES - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset)     cnt <= '0;
    else if (tick) cnt <= '0;
    else           cnt <= cnt + CW'(1);
  end
endmodule

// File: rtl/pong_engine.sv
// Pong game-logic core: paddles, ball, scores and match FSM, all advanced
// once per game tick.
//   clk, reset             : system clock, async active-high reset
//   start                  : level, starts/restarts a match (sampled on tick)
//   p1_up/down, p2_up/down : paddle controls, level
//   paddle1_y, paddle2_y   : paddle top edges
//   ball_x, ball_y         : ball top-left corner
//   ball_direction         : bit0 right, bit1 down
//   ball_speed             : horizontal pixels per tick
//   p1_score, p2_score     : scores
//   game_state             : state_t encoding
//   winner                 : 0 = player 1, 1 = player 2 (valid in OVER)
//   tick                   : one-cycle game-tick pulse
module pong_engine
  import pong_pkg::*;
#(
  parameter int H_RES        = DEF_H_RES,
  parameter int V_RES        = DEF_V_RES,
  parameter int PADDLE_H     = DEF_PADDLE_H,
  parameter int PADDLE_W     = DEF_PADDLE_W,
  parameter int PADDLE1_X    = DEF_PADDLE1_X,
  parameter int PADDLE2_X    = DEF_PADDLE2_X,
  parameter int BALL_SIZE    = DEF_BALL_SIZE,
  parameter int PADDLE_SPEED = DEF_PADDLE_SPEED,
  parameter int BALL_DY      = DEF_BALL_DY,
  parameter int SPEED_INIT   = DEF_SPEED_INIT,
  parameter int SPEED_MAX    = DEF_SPEED_MAX,
  parameter int TICK_CYCLES  = DEF_TICK_CYCLES,
  parameter int SERVE_TICKS  = DEF_SERVE_TICKS,
  parameter int WIN_SCORE    = DEF_WIN_SCORE
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       p1_up,
  input  logic       p1_down,
  input  logic       p2_up,
  input  logic       p2_down,
  output logic [9:0] paddle1_y,
  output logic [9:0] paddle2_y,
  output logic [9:0] ball_x,
  output logic [9:0] ball_y,
  output logic [1:0] ball_direction,
  output logic [2:0] ball_speed,
  output logic [3:0] p1_score,
  output logic [3:0] p2_score,
  output logic [2:0] game_state,
  output logic       winner,
  output logic       tick
);
  localparam int SCW = $clog2(SERVE_TICKS + 1);

  localparam logic [10:0] L_HRES  = 11'(H_RES);
  localparam logic [10:0] L_VRES  = 11'(V_RES);
  localparam logic [10:0] L_PH    = 11'(PADDLE_H);
  localparam logic [10:0] L_BS    = 11'(BALL_SIZE);
  localparam logic [10:0] L_DY    = 11'(BALL_DY);
  localparam logic [10:0] L_PS    = 11'(PADDLE_SPEED);
  localparam logic [10:0] L_P1E   = 11'(PADDLE1_X + PADDLE_W);  // paddle 1 right face
  localparam logic [10:0] L_P2X   = 11'(PADDLE2_X);
  localparam logic [10:0] L_PYMAX = 11'(V_RES - PADDLE_H);

  localparam logic [9:0] PAD_C = 10'((V_RES - PADDLE_H) / 2);
  localparam logic [9:0] X_C   = 10'((H_RES - BALL_SIZE) / 2);
  localparam logic [9:0] Y_C   = 10'((V_RES - BALL_SIZE) / 2);
  localparam logic [2:0] SP_I  = 3'(SPEED_INIT);
  localparam logic [2:0] SP_M  = 3'(SPEED_MAX);
  localparam logic [3:0] WIN   = 4'(WIN_SCORE);

  state_t           state, state_n;
  logic [SCW-1:0]   serve_cnt, serve_n;
  logic             scorer, scorer_n;   // 1 = player 2 took the last point
  logic [9:0]       p1y_n, p2y_n, bx_n, by_n;
  logic [1:0]       dir_n;
  logic [2:0]       spd_n, spd_up;
  logic [3:0]       s1_n, s2_n, sc_next;
  logic             win_n;

  logic [10:0]      x11, y11, sp11, p1y11, p2y11;
  logic             ov1, ov2, hit1, hit2, miss;

  pong_tick_gen #(.TICK_CYCLES(TICK_CYCLES)) u_tick (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

  assign game_state = state;

  assign x11   = {1'b0, ball_x};
  assign y11   = {1'b0, ball_y};
  assign sp11  = {8'd0, ball_speed};
  assign p1y11 = {1'b0, paddle1_y};
  assign p2y11 = {1'b0, paddle2_y};

  // Vertical overlap against the paddles as they stood before this tick.
  assign ov1  = (y11 + L_BS > p1y11) && (y11 < p1y11 + L_PH);
  assign ov2  = (y11 + L_BS > p2y11) && (y11 < p2y11 + L_PH);
  // x - speed <= face rewritten as x <= face + speed to stay unsigned.
  assign hit1 = !ball_direction[DIR_RIGHT] && (x11 >= L_P1E) &&
                (x11 <= L_P1E + sp11) && ov1;
  assign hit2 = ball_direction[DIR_RIGHT] && (x11 + L_BS <= L_P2X) &&
                (x11 + L_BS + sp11 >= L_P2X) && ov2;
  assign miss = ball_direction[DIR_RIGHT] ? (x11 + L_BS + sp11 > L_HRES)
                                          : (x11 < sp11);

  assign spd_up  = (ball_speed >= SP_M) ? SP_M : ball_speed + 3'd1;
  assign sc_next = (scorer ? p2_score : p1_score) + 4'd1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= ST_IDLE;
      serve_cnt      <= '0;
      scorer         <= 1'b0;
      paddle1_y      <= PAD_C;
      paddle2_y      <= PAD_C;
      ball_x         <= X_C;
      ball_y         <= Y_C;
      ball_direction <= 2'b01;
      ball_speed     <= SP_I;
      p1_score       <= '0;
      p2_score       <= '0;
      winner         <= 1'b0;
    end else begin
      state          <= state_n;
      serve_cnt      <= serve_n;
      scorer         <= scorer_n;
      paddle1_y      <= p1y_n;
      paddle2_y      <= p2y_n;
      ball_x         <= bx_n;
      ball_y         <= by_n;
      ball_direction <= dir_n;
      ball_speed     <= spd_n;
      p1_score       <= s1_n;
      p2_score       <= s2_n;
      winner         <= win_n;
    end
  end

  always_comb begin
    state_n  = state;
    serve_n  = serve_cnt;
    scorer_n = scorer;
    p1y_n    = paddle1_y;
    p2y_n    = paddle2_y;
    bx_n     = ball_x;
    by_n     = ball_y;
    dir_n    = ball_direction;
    spd_n    = ball_speed;
    s1_n     = p1_score;
    s2_n     = p2_score;
    win_n    = winner;
    if (tick) begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state_n = ST_SERVE;
            serve_n = '0;
          end
        end
        ST_SERVE: begin
          p1y_n = paddle_next(paddle1_y, p1_up, p1_down, L_PS, L_PYMAX);
          p2y_n = paddle_next(paddle2_y, p2_up, p2_down, L_PS, L_PYMAX);
          if (serve_cnt == SCW'(SERVE_TICKS - 1)) state_n = ST_PLAY;
          else                                    serve_n = serve_cnt + SCW'(1);
        end
        ST_PLAY: begin
          p1y_n = paddle_next(paddle1_y, p1_up, p1_down, L_PS, L_PYMAX);
          p2y_n = paddle_next(paddle2_y, p2_up, p2_down, L_PS, L_PYMAX);
          if (!(hit1 || hit2) && miss) begin
            // Ball freezes where it is; POINT settles the score.
            state_n  = ST_POINT;
            scorer_n = ~ball_direction[DIR_RIGHT];
          end else begin
            if (ball_direction[DIR_DOWN]) begin
              if (y11 + L_BS + L_DY >= L_VRES) begin
                by_n            = 10'(L_VRES - L_BS);
                dir_n[DIR_DOWN] = 1'b0;
              end else by_n = 10'(y11 + L_DY);
            end else begin
              if (y11 <= L_DY) begin
                by_n            = 10'd0;
                dir_n[DIR_DOWN] = 1'b1;
              end else by_n = 10'(y11 - L_DY);
            end
            if (hit1) begin
              bx_n             = 10'(L_P1E);
              dir_n[DIR_RIGHT] = 1'b1;
              spd_n            = spd_up;
            end else if (hit2) begin
              bx_n             = 10'(L_P2X - L_BS);
              dir_n[DIR_RIGHT] = 1'b0;
              spd_n            = spd_up;
            end else if (ball_direction[DIR_RIGHT]) bx_n = 10'(x11 + sp11);
            else                                     bx_n = 10'(x11 - sp11);
          end
        end
        ST_POINT: begin
          if (scorer) s2_n = sc_next;
          else        s1_n = sc_next;
          if (sc_next == WIN) begin
            state_n = ST_OVER;
            win_n   = scorer;
          end else begin
            bx_n             = X_C;
            by_n             = Y_C;
            spd_n            = SP_I;
            dir_n[DIR_RIGHT] = ~scorer;  // serve toward whoever conceded
            state_n          = ST_SERVE;
            serve_n          = '0;
          end
        end
        ST_OVER: begin
          if (start) begin
            s1_n    = '0;
            s2_n    = '0;
            win_n   = 1'b0;
            bx_n    = X_C;
            by_n    = Y_C;
            spd_n   = SP_I;
            state_n = ST_SERVE;
            serve_n = '0;
          end
        end
        default: state_n = ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_pong_engine.sv
module tb_pong_engine;
  logic       clk = 1'b0;
  logic       reset, start, p1_up, p1_down, p2_up, p2_down;
  logic [9:0] paddle1_y, paddle2_y, ball_x, ball_y;
  logic [1:0] ball_direction;
  logic [2:0] ball_speed, game_state;
  logic [3:0] p1_score, p2_score;
  logic       winner, tick;

  int n_run = 0, n_fail = 0;

  localparam int IDLE = 0, SERVE = 1, PLAY = 2, POINT = 3, OVER = 4;

  pong_engine #(.TICK_CYCLES(4), .SERVE_TICKS(2), .WIN_SCORE(2)) dut (
    .clk(clk), .reset(reset), .start(start),
    .p1_up(p1_up), .p1_down(p1_down), .p2_up(p2_up), .p2_down(p2_down),
    .paddle1_y(paddle1_y), .paddle2_y(paddle2_y),
    .ball_x(ball_x), .ball_y(ball_y), .ball_direction(ball_direction),
    .ball_speed(ball_speed), .p1_score(p1_score), .p2_score(p2_score),
    .game_state(game_state), .winner(winner), .tick(tick)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance n game ticks; return #1 after the edge that applies the last one.
  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      int c;
      c = 0;
      do begin
        @(negedge clk);
        c++;
      end while (!tick && c < 16);
      if (!tick) chk("tick_timeout", {31'd0, tick}, 32'd1);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk_ball(input string tag, input int x, input int y);
    chk({tag, "_x"}, {22'd0, ball_x}, x);
    chk({tag, "_y"}, {22'd0, ball_y}, y);
  endtask

  initial begin
    int c;
    reset = 1'b1; start = 1'b0;
    p1_up = 1'b0; p1_down = 1'b0; p2_up = 1'b0; p2_down = 1'b0;
    #12;
    chk("rst_p1y", {22'd0, paddle1_y}, 210);
    chk("rst_p2y", {22'd0, paddle2_y}, 210);
    chk_ball("rst", 316, 236);
    chk("rst_dir", {30'd0, ball_direction}, 1);
    chk("rst_spd", {29'd0, ball_speed}, 2);
    chk("rst_score", {24'd0, p1_score, p2_score}, 0);
    chk("rst_state", {29'd0, game_state}, IDLE);
    chk("rst_win", {31'd0, winner}, 0);
    chk("rst_tick", {31'd0, tick}, 0);

    @(negedge clk) reset = 1'b0;
    c = 0;
    do begin @(negedge clk); c++; end while (!tick && c < 16);
    chk("first_tick", c, 3);
    c = 0;
    do begin @(negedge clk); c++; end while (!tick && c < 16);
    chk("tick_period", c, 4);
    ticks(3);
    chk("idle_hold", {29'd0, game_state}, IDLE);

    // Rally 1: p1 drives to bottom limit, p2 to top limit; p1 wins the point.
    start = 1'b1; p1_down = 1'b1; p2_up = 1'b1;
    ticks(1);
    chk("serve_enter", {29'd0, game_state}, SERVE);
    chk("serve_p1y0", {22'd0, paddle1_y}, 210);
    start = 1'b0;
    ticks(1);
    chk("serve_p1y1", {22'd0, paddle1_y}, 214);
    chk("serve_p2y1", {22'd0, paddle2_y}, 206);
    ticks(1);
    chk("play_enter", {29'd0, game_state}, PLAY);
    chk_ball("serve_held", 316, 236);
    ticks(1);
    chk_ball("play1", 318, 234);
    ticks(116);
    chk_ball("pre_top", 550, 2);
    ticks(1);
    chk_ball("top", 552, 0);
    chk("top_dir", {30'd0, ball_direction}, 3);
    chk("p1_limit", {22'd0, paddle1_y}, 420);
    chk("p2_limit", {22'd0, paddle2_y}, 0);
    ticks(28);
    chk_ball("hit2", 608, 56);
    chk("hit2_dir", {30'd0, ball_direction}, 2);
    chk("hit2_spd", {29'd0, ball_speed}, 3);
    ticks(195);
    chk_ball("hit1", 24, 446);
    chk("hit1_dir", {30'd0, ball_direction}, 3);
    chk("hit1_spd", {29'd0, ball_speed}, 4);
    chk("p1_still", {22'd0, paddle1_y}, 420);
    ticks(13);
    chk_ball("bottom", 76, 472);
    chk("bottom_dir", {30'd0, ball_direction}, 1);
    ticks(140);
    chk("miss_r_state", {29'd0, game_state}, POINT);
    chk_ball("miss_r_held", 632, 194);
    chk("miss_r_s1", {28'd0, p1_score}, 0);
    ticks(1);
    chk("pt1_state", {29'd0, game_state}, SERVE);
    chk("pt1_s1", {28'd0, p1_score}, 1);
    chk_ball("pt1_ctr", 316, 236);
    chk("pt1_dir", {30'd0, ball_direction}, 1);
    chk("pt1_spd", {29'd0, ball_speed}, 2);

    // Rally 2: p1 leaves, p2 pushes both buttons (holds); p2 wins the point.
    p1_down = 1'b0; p1_up = 1'b1; p2_down = 1'b1;
    ticks(2);
    chk("r2_play", {29'd0, game_state}, PLAY);
    chk("both_hold", {22'd0, paddle2_y}, 0);
    ticks(341);
    chk_ball("r2_pass", 23, 446);
    chk("r2_dir", {30'd0, ball_direction}, 2);
    chk("p1_top", {22'd0, paddle1_y}, 0);
    ticks(8);
    chk("miss_l_state", {29'd0, game_state}, POINT);
    chk_ball("miss_l_held", 2, 460);
    ticks(1);
    chk("pt2_state", {29'd0, game_state}, SERVE);
    chk("pt2_s2", {28'd0, p2_score}, 1);
    chk_ball("pt2_ctr", 316, 236);
    chk("pt2_dir", {30'd0, ball_direction}, 2);

    // Rally 3: ball goes left-down, bounces, p1 misses -> p2 takes the match.
    ticks(2);
    chk("r3_play", {29'd0, game_state}, PLAY);
    ticks(118);
    chk_ball("r3_bottom", 80, 472);
    chk("r3_dir", {30'd0, ball_direction}, 0);
    ticks(41);
    chk("r3_point", {29'd0, game_state}, POINT);
    chk_ball("r3_held", 0, 392);
    ticks(1);
    chk("over_state", {29'd0, game_state}, OVER);
    chk("over_s2", {28'd0, p2_score}, 2);
    chk("over_s1", {28'd0, p1_score}, 1);
    chk("over_win", {31'd0, winner}, 1);
    ticks(3);
    chk("over_hold", {29'd0, game_state}, OVER);
    chk_ball("over_frozen", 0, 392);
    start = 1'b1;
    ticks(1);
    start = 1'b0;
    chk("restart_state", {29'd0, game_state}, SERVE);
    chk("restart_score", {24'd0, p1_score, p2_score}, 0);
    chk("restart_win", {31'd0, winner}, 0);
    chk_ball("restart_ctr", 316, 236);

    // Asynchronous reset in the middle of a cycle.
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("arst_p1y", {22'd0, paddle1_y}, 210);
    chk("arst_state", {29'd0, game_state}, IDLE);
    chk_ball("arst", 316, 236);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
